memory_bank: RTL and testbench



---
 rtl/memory_bank.sv | 235 +++++++++++++++++++++++
 tb/tb_memory_bank.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bank.sv
// memory_bank -- on-chip core memory bank for an 18-bit word address space,
// behind an Avalon-MM style slave port with waitrequest.
//
// The bank answers only inside its address window, which is BASE[17:ADDR_WIDTH].
// An access outside the window leaves waitrequest high, so the master's
// nonexistent-memory timeout fires. Several banks can share one bus.
// A write is acknowledged one cycle after it is seen. A read is acknowledged
// RD_WAIT+2 cycles after it is seen. An optional sweep zero-fills the bank
// after reset.
//
// Optional feature: define MEMORY_BANK_PARITY_EN to store an odd-parity bit
// with every word and check it on reads.
//
// Ports:
//   i_clk          clock
//   i_reset_n      asynchronous active-low reset
//   i_address      18-bit word address
//   i_read         read request, held until acknowledged
//   i_write        write request, held until acknowledged (wins over read)
//   i_writedata    write data
//   o_readdata     read data, valid in the ack cycle, held until the next read ack
//   o_waitrequest  low for exactly one cycle per completed transfer
//   o_busy         high while the clear sweep runs
//   o_parity_err   one-cycle pulse in the ack cycle of a read whose parity is bad
module memory_bank #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter logic [17:0] BASE           = 18'o000000,
  parameter int unsigned DATA_WIDTH     = 36,
  parameter int unsigned RD_WAIT        = 0,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [17:0]           i_address,
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [DATA_WIDTH-1:0] i_writedata,
  output logic [DATA_WIDTH-1:0] o_readdata,
  output logic                  o_waitrequest,
  output logic                  o_busy,
  output logic                  o_parity_err
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
`ifdef MEMORY_BANK_PARITY_EN
  localparam int unsigned RAM_W = DATA_WIDTH + 1;
`else
  localparam int unsigned RAM_W = DATA_WIDTH;
`endif
  localparam logic [ADDR_WIDTH-1:0] SWEEP_LAST = '1;
  localparam logic [3:0]            WAIT_LAST  = 4'(RD_WAIT);

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_IDLE  = 3'd1,
    S_WR    = 3'd2,
    S_RD    = 3'd3,
    S_ACK   = 3'd4
  } state_t;

  localparam state_t RESET_STATE = state_t'(CLEAR_ON_RESET ? S_CLEAR : S_IDLE);

  // Builds a stored RAM word from data. With parity enabled, the top bit
  // holds the odd parity of the data, so the all-zero word stores parity 1.
  function automatic logic [RAM_W-1:0] encode_word(input logic [DATA_WIDTH-1:0] d);
`ifdef MEMORY_BANK_PARITY_EN
    return {~^d, d};
`else
    return d;
`endif
  endfunction

`ifdef MEMORY_BANK_PARITY_EN
  // Returns 1 when the stored parity bit disagrees with the recomputed parity.
  function automatic logic parity_bad(input logic [RAM_W-1:0] w);
    return (~^w[DATA_WIDTH-1:0]) != w[DATA_WIDTH];
  endfunction
`endif

  logic [RAM_W-1:0]      mem [DEPTH];
  state_t                state_r, next_state_s;
  logic [ADDR_WIDTH-1:0] sweep_r;
  logic [3:0]            wait_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [DATA_WIDTH-1:0] q_r;
  logic                  waitrequest_r;
  logic                  busy_r;
  logic                  hit_s;
  logic                  core_we_s;
  logic                  ram_we_s;
  logic [ADDR_WIDTH-1:0] ram_waddr_s;
  logic [RAM_W-1:0]      ram_wdata_s;
  logic                  load_q_s;

  // A full-width bank owns the whole address space; otherwise compare the
  // upper bits only, so out-of-window addresses never alias into the bank.
  if (ADDR_WIDTH >= 18) begin : g_full_window
    assign hit_s = 1'b1;
  end else begin : g_window
    assign hit_s = (i_address[17:ADDR_WIDTH] == BASE[17:ADDR_WIDTH]);
  end

  // The state register is held at CLEAR (or IDLE) while reset is low.
  // Gating with reset keeps the RAM from being written during that time.
  assign ram_we_s = core_we_s & i_reset_n;

  // Next-state, RAM write port and read-load decode
  always_comb begin
    next_state_s = state_r;
    core_we_s    = 1'b0;
    ram_waddr_s  = sweep_r;
    ram_wdata_s  = encode_word('0);
    load_q_s     = 1'b0;
    case (state_r)
      S_CLEAR: begin
        core_we_s   = 1'b1;
        ram_waddr_s = sweep_r;
        ram_wdata_s = encode_word('0);
        if (sweep_r == SWEEP_LAST) begin
          next_state_s = S_IDLE;
        end else begin
          next_state_s = S_CLEAR;
        end
      end
      S_IDLE: begin
        if (i_write && hit_s) begin
          next_state_s = S_WR;
        end else if (i_read && hit_s) begin
          next_state_s = S_RD;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_WR: begin
        core_we_s    = 1'b1;
        ram_waddr_s  = addr_r;
        ram_wdata_s  = encode_word(wdata_r);
        next_state_s = S_IDLE;
      end
      S_RD: begin
        if (wait_r == WAIT_LAST) begin
          load_q_s     = 1'b1;
          next_state_s = S_ACK;
        end else begin
          next_state_s = S_RD;
        end
      end
      S_ACK: begin
        next_state_s = S_IDLE;
      end
      default: begin
        next_state_s = RESET_STATE;
      end
    endcase
  end

  // Control registers: state, sweep and wait counters, latched request, handshake outputs
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r       <= RESET_STATE;
      sweep_r       <= '0;
      wait_r        <= 4'd0;
      addr_r        <= '0;
      wdata_r       <= '0;
      waitrequest_r <= 1'b1;
      busy_r        <= CLEAR_ON_RESET;
    end else begin
      state_r <= next_state_s;
      if (state_r == S_CLEAR) begin
        sweep_r <= sweep_r + ADDR_WIDTH'(1'b1);
      end else begin
        sweep_r <= sweep_r;
      end
      if ((state_r == S_RD) && (next_state_s == S_RD)) begin
        wait_r <= wait_r + 4'd1;
      end else begin
        wait_r <= 4'd0;
      end
      // The transfer runs from the latched copy, so a master that drops or
      // changes the bus before the ack does not disturb it.
      if ((state_r == S_IDLE) && (next_state_s != S_IDLE)) begin
        addr_r  <= i_address[ADDR_WIDTH-1:0];
        wdata_r <= i_writedata;
      end else begin
        addr_r  <= addr_r;
        wdata_r <= wdata_r;
      end
      waitrequest_r <= !((next_state_s == S_WR) || (next_state_s == S_ACK));
      busy_r        <= (next_state_s == S_CLEAR);
    end
  end

  // RAM array write port (no reset on storage)
  always_ff @(posedge i_clk) begin
    if (ram_we_s) begin
      mem[ram_waddr_s] <= ram_wdata_s;
    end
  end

  // Registered read port; it loads only on entry to ACK and then holds
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      q_r <= '0;
    end else if (load_q_s) begin
      q_r <= mem[addr_r][DATA_WIDTH-1:0];
    end else begin
      q_r <= q_r;
    end
  end

`ifdef MEMORY_BANK_PARITY_EN
  logic parity_err_r;

  // Parity check, registered alongside the read data so it lines up with the ack
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      parity_err_r <= 1'b0;
    end else if (load_q_s) begin
      parity_err_r <= parity_bad(mem[addr_r]);
    end else begin
      parity_err_r <= 1'b0;
    end
  end

  assign o_parity_err = parity_err_r;
`else
  assign o_parity_err = 1'b0;
`endif

  assign o_readdata    = q_r;
  assign o_waitrequest = waitrequest_r;
  assign o_busy        = busy_r;

endmodule

// File: tb/tb_memory_bank.sv
// tb_memory_bank -- directed, table-driven bench for memory_bank.
// Two banks share one bus:
//   bank A: base 200000, 16 words, no read wait states, cleared on reset.
//   bank B: base 100000, 16 words, 3 read wait states, no clear sweep.
module tb_memory_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [17:0] address = 18'd0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [35:0] wdata = 36'd0;
  logic [35:0] q_a, q_b;
  logic        wreq_a, wreq_b, busy_a, busy_b, pe_a, pe_b;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  memory_bank #(.ADDR_WIDTH(4), .BASE(18'o200000), .DATA_WIDTH(36),
                .RD_WAIT(0), .CLEAR_ON_RESET(1'b1)) dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_address(address), .i_read(rd),
    .i_write(wr), .i_writedata(wdata), .o_readdata(q_a),
    .o_waitrequest(wreq_a), .o_busy(busy_a), .o_parity_err(pe_a));

  memory_bank #(.ADDR_WIDTH(4), .BASE(18'o100000), .DATA_WIDTH(36),
                .RD_WAIT(3), .CLEAR_ON_RESET(1'b0)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_address(address), .i_read(rd),
    .i_write(wr), .i_writedata(wdata), .o_readdata(q_b),
    .o_waitrequest(wreq_b), .o_busy(busy_b), .o_parity_err(pe_b));

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [17:0] addr;
    logic [35:0] wdata;
    logic [35:0] exp_q;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Holds the request until either bank acks it, within a bounded wait.
  // It returns #1 after the edge that ends the ack cycle, with the request
  // still driven, so a caller can chain a back-to-back transfer.
  task automatic xfer(input logic r, input logic w, input logic [17:0] a,
                      input logic [35:0] d, output int lat, output logic [35:0] q,
                      output logic pe, output int ack_cyc);
    rd = r; wr = w; address = a; wdata = d;
    lat = -1; q = 36'd0; pe = 1'b0; ack_cyc = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!wreq_a || !wreq_b) begin
        lat = k;
        ack_cyc = cyc;
        q  = !wreq_a ? q_a : q_b;
        pe = !wreq_a ? pe_a : pe_b;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    rd = 1'b0; wr = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat2, ac1, ac2, busy_cnt, bad;
    logic [35:0] q;
    logic pe;

    vecs[0] = '{"wr_a5",    1'b0, 1'b1, 18'o200005, 36'o123456701234, 36'd0, 1};
    vecs[1] = '{"rd_a5",    1'b1, 1'b0, 18'o200005, 36'd0, 36'o123456701234, 2};
    vecs[2] = '{"wr_a17",   1'b0, 1'b1, 18'o200017, 36'o777777777777, 36'd0, 1};
    vecs[3] = '{"rd_a17",   1'b1, 1'b0, 18'o200017, 36'd0, 36'o777777777777, 2};
    vecs[4] = '{"rd_a6",    1'b1, 1'b0, 18'o200006, 36'd0, 36'd0, 2};
    vecs[5] = '{"wr_b1",    1'b0, 1'b1, 18'o100001, 36'o000000000011, 36'd0, 1};
    vecs[6] = '{"wr_b2",    1'b0, 1'b1, 18'o100002, 36'o525252525252, 36'd0, 1};
    vecs[7] = '{"rd_b1",    1'b1, 1'b0, 18'o100001, 36'd0, 36'o000000000011, 5};
    vecs[8] = '{"rdwr_a10", 1'b1, 1'b1, 18'o200010, 36'o000000000001, 36'd0, 1};
    vecs[9] = '{"rd_a10",   1'b1, 1'b0, 18'o200010, 36'd0, 36'o000000000001, 2};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_wreq_a", wreq_a, 1'b1);
    chk("rst_wreq_b", wreq_b, 1'b1);
    chk("rst_busy_a", busy_a, 1'b1);
    chk("rst_busy_b", busy_b, 1'b0);
    chk("rst_q_a", q_a, 36'd0);
    chk("rst_pe_a", pe_a, 1'b0);

    // Release reset with a read of word 0 already requested. Bank A sweeps
    // for 16 cycles, then acks the read.
    @(posedge clk); #1;
    rst_n = 1'b1; rd = 1'b1; address = 18'o200000;
    busy_cnt = 0; lat = -1; q = 36'hf;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (busy_a) busy_cnt++;
      if (!wreq_a) begin lat = k; q = q_a; break; end
    end
    chk("sweep_busy_cycles", busy_cnt, 16);
    chk("sweep_read_lat", lat, 18);
    chk("sweep_read_data", q, 36'd0);
    @(posedge clk); #1;
    idle();

    // Table-driven transfers
    for (int i = 0; i < 10; i++) begin
      xfer(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, q, pe, ac1);
      chk({vecs[i].name, "_lat"}, lat, vecs[i].exp_lat);
      if (vecs[i].rd && !vecs[i].wr) begin
        chk({vecs[i].name, "_data"}, q, vecs[i].exp_q);
        chk({vecs[i].name, "_pe"}, pe, 1'b0);
      end
      idle();
    end

    // Back-to-back reads on bank B are spaced RD_WAIT+3 = 6 cycles apart
    xfer(1'b1, 1'b0, 18'o100001, 36'd0, lat, q, pe, ac1);
    chk("b2b_rd1_data", q, 36'o000000000011);
    xfer(1'b1, 1'b0, 18'o100002, 36'd0, lat2, q, pe, ac2);
    chk("b2b_rd2_data", q, 36'o525252525252);
    chk("b2b_rd2_lat", lat2, 5);
    chk("b2b_rd_spacing", ac2 - ac1, 6);
    idle();

    // Back-to-back writes on bank A are spaced 2 cycles apart
    xfer(1'b0, 1'b1, 18'o200011, 36'o111111111111, lat, q, pe, ac1);
    xfer(1'b0, 1'b1, 18'o200012, 36'o222222222222, lat2, q, pe, ac2);
    chk("b2b_wr_spacing", ac2 - ac1, 2);
    idle();
    xfer(1'b1, 1'b0, 18'o200011, 36'd0, lat, q, pe, ac1);
    chk("b2b_wr1_data", q, 36'o111111111111);
    idle();
    xfer(1'b1, 1'b0, 18'o200012, 36'd0, lat, q, pe, ac1);
    chk("b2b_wr2_data", q, 36'o222222222222);
    idle();

    // A read outside both windows is never acknowledged
    rd = 1'b1; address = 18'o000005; bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!wreq_a || !wreq_b) bad++;
    end
    chk("miss_read_no_ack", bad, 0);
    idle();
    // A write just above A's window must not alias onto word 5
    wr = 1'b1; address = 18'o200025; wdata = 36'o666666666666; bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!wreq_a || !wreq_b) bad++;
    end
    chk("miss_write_no_ack", bad, 0);
    idle();
    xfer(1'b1, 1'b0, 18'o200005, 36'd0, lat, q, pe, ac1);
    chk("miss_mem_unchanged", q, 36'o123456701234);
    idle();

    // Write dropped in the ack cycle with the bus changed: the latched
    // address and data are committed
    wr = 1'b1; address = 18'o200013; wdata = 36'o135713571357;
    @(posedge clk); #1;
    wr = 1'b0; address = 18'o200014; wdata = 36'o444444444444;
    @(negedge clk);
    chk("drop_wr_ack", wreq_a, 1'b0);
    @(posedge clk); #1;
    idle();
    // Read dropped one cycle after being seen still acks with the right data
    rd = 1'b1; address = 18'o200013;
    @(posedge clk); #1;
    rd = 1'b0; address = 18'o200014;
    @(negedge clk);
    chk("drop_rd_wait", wreq_a, 1'b1);
    @(negedge clk);
    chk("drop_rd_ack", wreq_a, 1'b0);
    chk("drop_rd_data", q_a, 36'o135713571357);
    @(posedge clk); #1;
    idle();
    xfer(1'b1, 1'b0, 18'o200014, 36'd0, lat, q, pe, ac1);
    chk("drop_wr_no_stray", q, 36'd0);
    idle();
    // o_readdata holds its value after the ack
    @(negedge clk);
    chk("readdata_hold", q_a, 36'd0);

    // Reset asserted in the cycle the write is waiting to commit
    wr = 1'b1; address = 18'o200003; wdata = 36'o707070707070;
    @(posedge clk); #1;
    rst_n = 1'b0; wr = 1'b0;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (!wreq_a || !wreq_b || !busy_a) bad++;
    end
    chk("rst_mid_wr_wait", bad, 0);
    chk("rst_mid_q_a", q_a, 36'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    busy_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy_a) break;
      busy_cnt++;
    end
    chk("rst_resweep_cycles", busy_cnt, 16);
    @(posedge clk); #1;
    xfer(1'b1, 1'b0, 18'o200003, 36'd0, lat, q, pe, ac1);
    chk("rst_mid_wr_unwritten", q, 36'd0);
    idle();
    xfer(1'b1, 1'b0, 18'o200005, 36'd0, lat, q, pe, ac1);
    chk("rst_resweep_zero", q, 36'd0);
    idle();
    xfer(1'b1, 1'b0, 18'o100002, 36'd0, lat, q, pe, ac1);
    chk("rst_b_retains", q, 36'o525252525252);
    idle();

`ifdef MEMORY_BANK_PARITY_EN
    // Flip one stored data bit and read it back
    xfer(1'b0, 1'b1, 18'o200007, 36'o000000000377, lat, q, pe, ac1);
    idle();
    dut_a.mem[7] = dut_a.mem[7] ^ 37'h1;
    xfer(1'b1, 1'b0, 18'o200007, 36'd0, lat, q, pe, ac1);
    chk("par_bad_lat", lat, 2);
    chk("par_bad_pulse", pe, 1'b1);
    chk("par_bad_data", q, 36'o000000000376);
    rd = 1'b0;
    @(negedge clk);
    chk("par_pulse_one_cycle", pe_a, 1'b0);
    @(posedge clk); #1;
    xfer(1'b1, 1'b0, 18'o200005, 36'd0, lat, q, pe, ac1);
    chk("par_good_no_pulse", pe, 1'b0);
    idle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
